// File: rtl/flu_pkg.sv
// Shared field layout, opcode/operation encodings and issue FSM states for the FLU issue path.
package flu_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned OPC_W   = 7;

    localparam int unsigned OP_LSB  = 27;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned FRD_LSB = 7;
    localparam int unsigned OPC_LSB = 0;

    localparam logic [OPC_W-1:0] FLU_OPCODE = 7'b1001011;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3
    } flu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  operation;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] frd;
        logic [OPC_W-1:0] opcode;
    } flu_fields_t;

    // Only the FLU major opcode with one of the four arithmetic operations is issuable.
    function automatic logic flu_is_legal(input logic [OPC_W-1:0] opcode,
                                          input logic [OP_W-1:0]  operation);
        return (opcode == FLU_OPCODE) &&
               ((operation == OP_ADD) || (operation == OP_SUB) ||
                (operation == OP_MUL) || (operation == OP_DIV));
    endfunction

endpackage

// File: rtl/flu_issue_unit_if.sv
// Fetch, FLU issue and writeback signal bundle of the FLU issue unit.
interface flu_issue_unit_if;
    import flu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [WORD_W-1:0] instr_word;
    logic              issue_valid;
    logic              issue_ready;
    logic [WORD_W-1:0] issue_control;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_frd;

    modport slave (
        input  instr_valid, instr_word, issue_ready, wb_valid, wb_frd,
        output instr_ready, issue_valid, issue_control
    );

    modport master (
        output instr_valid, instr_word, issue_ready, wb_valid, wb_frd,
        input  instr_ready, issue_valid, issue_control
    );

endinterface

// File: rtl/flu_sync_fifo.sv
// Synchronous FIFO with synchronous active-low reset; head entry is readable combinationally.
module flu_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rdata_c = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/flu_issue_unit.sv
// FLU issue stage: buffers fetched words, drops illegal ones, holds hazarding ones, issues one at a time.
// Optional performance counters are enabled with `define FLU_ISSUE_PERF_EN.
module flu_issue_unit
    import flu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_FREGS  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    flu_issue_unit_if.slave bus,
    output logic            illegal_instr,
`ifdef FLU_ISSUE_PERF_EN
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall,
`endif
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    issue_state_e           state_q;
    issue_state_e           state_d;
    logic [WORD_W-1:0]      ctrl_q;
    logic [WORD_W-1:0]      ctrl_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   illegal_q;
    logic                   illegal_d;
    logic [NUM_FREGS-1:0]   sb_q;
    logic [NUM_FREGS-1:0]   sb_d;
    logic [NUM_FREGS-1:0]   sb_set;
    logic [NUM_FREGS-1:0]   sb_clr;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [WORD_W-1:0]      head_word;
    flu_fields_t            head_f;
    logic                   head_legal;
    logic                   head_hazard;

    assign fifo_push = bus.instr_valid && !fifo_full;

    flu_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (bus.instr_word),
        .rdata_c (head_word),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    assign head_f.operation = head_word[OP_LSB  +: OP_W];
    assign head_f.rs2       = head_word[RS2_LSB +: REG_W];
    assign head_f.rs1       = head_word[RS1_LSB +: REG_W];
    assign head_f.frd       = head_word[FRD_LSB +: REG_W];
    assign head_f.opcode    = head_word[OPC_LSB +: OPC_W];

    assign head_legal  = flu_is_legal(head_f.opcode, head_f.operation);
    // RAW on either source or WAW on the destination against in-flight results.
    assign head_hazard = sb_q[head_f.rs1] | sb_q[head_f.rs2] | sb_q[head_f.frd];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            sb_q      <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            sb_q      <= sb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        sb_set    = '0;
        fifo_pop  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty || fifo_push) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else if (!head_legal) begin
                    fifo_pop  = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = ((fifo_count > CNT_W'(1)) || fifo_push) ? S_CHECK : S_IDLE;
                end else if (!head_hazard) begin
                    fifo_pop = 1'b1;
                    ctrl_d   = head_word;
                    valid_d  = 1'b1;
                    sb_set   = NUM_FREGS'(1) << head_f.frd;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.issue_ready) begin
                    valid_d = 1'b0;
                    state_d = fifo_empty ? S_IDLE : S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A writeback clearing the register being issued this cycle loses to the new set.
    assign sb_clr = bus.wb_valid ? (NUM_FREGS'(1) << bus.wb_frd) : '0;
    assign sb_d   = (sb_q & ~sb_clr) | sb_set;

    assign bus.instr_ready   = !fifo_full;
    assign bus.issue_valid   = valid_q;
    assign bus.issue_control = ctrl_q;
    assign illegal_instr     = illegal_q;
    assign busy              = (fifo_count != '0) || (state_q == S_ISSUE) || (|sb_q);

`ifdef FLU_ISSUE_PERF_EN
    logic check_stall;

    assign check_stall = (state_q == S_CHECK) && !fifo_empty && head_legal && head_hazard;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (valid_q && bus.issue_ready) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (check_stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
